// File: rtl/seg_scan.sv
// seg_scan: four-digit multiplexed seven-segment display driver.
//
// Captures a 16-bit hex value plus four decimal points into a pending
// register on load, then commits pending to a shadow register at each frame
// boundary (phase wrapping from 3 to 0) so a frame never shows mixed data.
// Each cycle the digit selected by the upstream scan phase is decoded from
// the shadow and driven on registered outputs, one cycle after the phase
// was sampled.
//
// Parameters:
//   BLANK_LZ   - 1: blank leading zero digits (digit 0 is never blanked)
//   ACTIVE_LOW - 1: seg, dp and an are driven low for lit/selected
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset      - synchronous active-high reset
//   phase      - digit-scan phase from an upstream modulo-4 counter
//   data       - four hex nibbles, digit k is data[4k+3:4k]
//   load       - capture data/dp_in into the pending register
//   dp_in      - decimal point per digit, bit k belongs to digit k
//   seg        - segments {g,f,e,d,c,b,a} of the selected digit
//   dp         - decimal point of the selected digit
//   an         - one-hot digit enable, bit k is digit k
//   frame_done - one-cycle pulse the cycle after a frame boundary
//   seq_err    - sticky flag, set on an illegal phase step
module seg_scan #(
    parameter int unsigned BLANK_LZ   = 1,
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  phase,
    input  logic [15:0] data,
    input  logic        load,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_done,
    output logic        seq_err
);

    localparam logic Inv = (ACTIVE_LOW != 0);
    localparam logic BlankEn = (BLANK_LZ != 0);

    // Active-high hex decode, segment order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            4'hF: s = 7'b1110001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // State
    logic [15:0] pending_data_q, pending_data_d;
    logic [3:0]  pending_dp_q,   pending_dp_d;
    logic [15:0] shadow_data_q,  shadow_data_d;
    logic [3:0]  shadow_dp_q,    shadow_dp_d;
    logic [1:0]  prev_phase_q;
    logic        frame_done_q;
    logic        seq_err_q,      seq_err_d;
    logic [6:0]  seg_q,          seg_d;
    logic        dp_q,           dp_d;
    logic [3:0]  an_q,           an_d;

    // Combinational helpers
    logic       boundary;
    logic       step_ok;
    logic [3:0] nib;
    logic [3:0] zero_from;
    logic       blank;
    logic [6:0] seg_hi;
    logic [3:0] an_hi;
    logic       dp_hi;

    always_comb begin
        boundary = (phase == 2'd0) && (prev_phase_q == 2'd3);
        // Stall or advance by one (mod 4) are the only legal steps.
        step_ok  = (phase == prev_phase_q) || (phase == prev_phase_q + 2'd1);

        pending_data_d = pending_data_q;
        pending_dp_d   = pending_dp_q;
        if (load) begin
            pending_data_d = data;
            pending_dp_d   = dp_in;
        end

        // A load in the boundary cycle still commits the old pending value.
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        if (boundary) begin
            shadow_data_d = pending_data_q;
            shadow_dp_d   = pending_dp_q;
        end

        seq_err_d = seq_err_q | ~step_ok;
    end

    // Display path works from the post-commit shadow so the first digit of a
    // new frame already shows the newly committed value.
    always_comb begin
        nib = 4'h0;
        unique case (phase)
            2'd0: nib = shadow_data_d[3:0];
            2'd1: nib = shadow_data_d[7:4];
            2'd2: nib = shadow_data_d[11:8];
            2'd3: nib = shadow_data_d[15:12];
            default: nib = 4'h0;
        endcase

        // zero_from[k]: nibbles k..3 are all zero.
        zero_from[3] = (shadow_data_d[15:12] == 4'h0);
        zero_from[2] = zero_from[3] && (shadow_data_d[11:8] == 4'h0);
        zero_from[1] = zero_from[2] && (shadow_data_d[7:4] == 4'h0);
        zero_from[0] = zero_from[1] && (shadow_data_d[3:0] == 4'h0);

        blank  = BlankEn && (phase != 2'd0) && zero_from[phase];
        seg_hi = blank ? 7'b0000000 : hex7(nib);
        an_hi  = 4'b0001 << phase;
        dp_hi  = shadow_dp_d[phase];

        seg_d = Inv ? ~seg_hi : seg_hi;
        an_d  = Inv ? ~an_hi : an_hi;
        dp_d  = Inv ? ~dp_hi : dp_hi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_data_q <= 16'h0000;
            pending_dp_q   <= 4'h0;
            shadow_data_q  <= 16'h0000;
            shadow_dp_q    <= 4'h0;
            prev_phase_q   <= 2'd0;
            frame_done_q   <= 1'b0;
            seq_err_q      <= 1'b0;
            seg_q          <= {7{Inv}};
            dp_q           <= Inv;
            an_q           <= {4{Inv}};
        end else begin
            pending_data_q <= pending_data_d;
            pending_dp_q   <= pending_dp_d;
            shadow_data_q  <= shadow_data_d;
            shadow_dp_q    <= shadow_dp_d;
            prev_phase_q   <= phase;
            frame_done_q   <= boundary;
            seq_err_q      <= seq_err_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            an_q           <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;
    assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_seg_scan.sv
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  phase;
    logic [15:0] data;
    logic        load;
    logic [3:0]  dp_in;
    logic [6:0]  seg, seg_nb;
    logic        dp, dp_nb;
    logic [3:0]  an, an_nb;
    logic        frame_done, frame_done_nb;
    logic        seq_err, seq_err_nb;

    int checks = 0;
    int failures = 0;

    // Active-low segment constants {g,f,e,d,c,b,a}
    localparam logic [6:0] S_OFF = 7'b1111111;
    localparam logic [6:0] S_0   = 7'b1000000;
    localparam logic [6:0] S_1   = 7'b1111001;
    localparam logic [6:0] S_2   = 7'b0100100;
    localparam logic [6:0] S_7   = 7'b1111000;
    localparam logic [6:0] S_A   = 7'b0001000;
    localparam logic [6:0] S_F   = 7'b0001110;
    localparam logic [3:0] A_0   = 4'b1110;
    localparam logic [3:0] A_1   = 4'b1101;
    localparam logic [3:0] A_2   = 4'b1011;
    localparam logic [3:0] A_3   = 4'b0111;
    localparam logic [3:0] A_OFF = 4'b1111;

    seg_scan dut (
        .clk(clk), .reset(reset), .phase(phase), .data(data), .load(load),
        .dp_in(dp_in), .seg(seg), .dp(dp), .an(an),
        .frame_done(frame_done), .seq_err(seq_err)
    );

    seg_scan #(.BLANK_LZ(0), .ACTIVE_LOW(1)) dut_nb (
        .clk(clk), .reset(reset), .phase(phase), .data(data), .load(load),
        .dp_in(dp_in), .seg(seg_nb), .dp(dp_nb), .an(an_nb),
        .frame_done(frame_done_nb), .seq_err(seq_err_nb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic step(input logic rst, input logic [1:0] ph, input logic ld,
                        input logic [15:0] d, input logic [3:0] dpi);
        reset = rst; phase = ph; load = ld; data = d; dp_in = dpi;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic dig(input string tag, input logic [3:0] ea, input logic [6:0] es,
                       input logic ed, input logic ef, input logic ee);
        chk({tag, ".an"}, {12'h0, an}, {12'h0, ea});
        chk({tag, ".seg"}, {9'h0, seg}, {9'h0, es});
        chk({tag, ".dp"}, {15'h0, dp}, {15'h0, ed});
        chk({tag, ".fd"}, {15'h0, frame_done}, {15'h0, ef});
        chk({tag, ".err"}, {15'h0, seq_err}, {15'h0, ee});
    endtask

    initial begin
        // Reset state
        step(1'b1, 2'd0, 1'b0, 16'h0, 4'h0);
        step(1'b1, 2'd0, 1'b0, 16'h0, 4'h0);
        dig("rst", A_OFF, S_OFF, 1'b1, 1'b0, 1'b0);

        // Empty frame: digit 0 shows 0, leading zeros blanked
        step(1'b0, 2'd0, 1'b0, 16'h0, 4'h0); dig("e0", A_0, S_0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd1, 1'b0, 16'h0, 4'h0); dig("e1", A_1, S_OFF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd2, 1'b0, 16'h0, 4'h0); dig("e2", A_2, S_OFF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd3, 1'b0, 16'h0, 4'h0); dig("e3", A_3, S_OFF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 16'h0, 4'h0); dig("e0b", A_0, S_0, 1'b1, 1'b1, 1'b0);

        // Mid-frame load 12AF with dp on digit 2: held until boundary
        step(1'b0, 2'd1, 1'b1, 16'h12AF, 4'b0100); dig("l1", A_1, S_OFF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd2, 1'b0, 16'h0, 4'h0); dig("l2", A_2, S_OFF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd3, 1'b0, 16'h0, 4'h0); dig("l3", A_3, S_OFF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 16'h0, 4'h0); dig("f0", A_0, S_F, 1'b1, 1'b1, 1'b0);
        step(1'b0, 2'd1, 1'b0, 16'h0, 4'h0); dig("f1", A_1, S_A, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd2, 1'b0, 16'h0, 4'h0); dig("f2", A_2, S_2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'd3, 1'b0, 16'h0, 4'h0); dig("f3", A_3, S_1, 1'b1, 1'b0, 1'b0);

        // Leading-zero blanking with 0070, compared against the unblanked copy
        step(1'b0, 2'd0, 1'b0, 16'h0, 4'h0);
        step(1'b0, 2'd1, 1'b1, 16'h0070, 4'h0);
        step(1'b0, 2'd2, 1'b0, 16'h0, 4'h0);
        step(1'b0, 2'd3, 1'b0, 16'h0, 4'h0);
        step(1'b0, 2'd0, 1'b0, 16'h0, 4'h0); dig("z0", A_0, S_0, 1'b1, 1'b1, 1'b0);
        chk("z0.nb", {9'h0, seg_nb}, {9'h0, S_0});
        step(1'b0, 2'd1, 1'b0, 16'h0, 4'h0); dig("z1", A_1, S_7, 1'b1, 1'b0, 1'b0);
        chk("z1.nb", {9'h0, seg_nb}, {9'h0, S_7});
        step(1'b0, 2'd2, 1'b0, 16'h0, 4'h0); dig("z2", A_2, S_OFF, 1'b1, 1'b0, 1'b0);
        chk("z2.nb", {9'h0, seg_nb}, {9'h0, S_0});
        chk("z2.nban", {12'h0, an_nb}, {12'h0, A_2});
        step(1'b0, 2'd3, 1'b0, 16'h0, 4'h0); dig("z3", A_3, S_OFF, 1'b1, 1'b0, 1'b0);
        chk("z3.nb", {9'h0, seg_nb}, {9'h0, S_0});

        // Load 1111, then 2222 in the boundary cycle
        step(1'b0, 2'd0, 1'b0, 16'h0, 4'h0);
        step(1'b0, 2'd1, 1'b1, 16'h1111, 4'h0);
        step(1'b0, 2'd2, 1'b0, 16'h0, 4'h0);
        step(1'b0, 2'd3, 1'b0, 16'h0, 4'h0);
        step(1'b0, 2'd0, 1'b1, 16'h2222, 4'h0); dig("o0", A_0, S_1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 2'd1, 1'b0, 16'h0, 4'h0); dig("o1", A_1, S_1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd2, 1'b0, 16'h0, 4'h0);
        // Stall at phase 2 is legal
        step(1'b0, 2'd2, 1'b0, 16'h0, 4'h0);
        step(1'b0, 2'd2, 1'b0, 16'h0, 4'h0); dig("o2", A_2, S_1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd3, 1'b0, 16'h0, 4'h0); dig("o3", A_3, S_1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 16'h0, 4'h0); dig("t0", A_0, S_2, 1'b1, 1'b1, 1'b0);
        step(1'b0, 2'd1, 1'b0, 16'h0, 4'h0); dig("t1", A_1, S_2, 1'b1, 1'b0, 1'b0);

        // Illegal step 1->3, sticky through legal frames, display continues
        step(1'b0, 2'd3, 1'b0, 16'h0, 4'h0); dig("x3", A_3, S_2, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 16'h0, 4'h0); dig("x0", A_0, S_2, 1'b1, 1'b1, 1'b1);
        step(1'b0, 2'd1, 1'b0, 16'h0, 4'h0);
        step(1'b0, 2'd2, 1'b0, 16'h0, 4'h0);
        step(1'b0, 2'd3, 1'b0, 16'h0, 4'h0);
        step(1'b0, 2'd0, 1'b0, 16'h0, 4'h0); dig("x0b", A_0, S_2, 1'b1, 1'b1, 1'b1);

        // Reset at phase 2 with a pending load
        step(1'b0, 2'd1, 1'b1, 16'h5555, 4'hF);
        step(1'b1, 2'd2, 1'b0, 16'h0, 4'h0); dig("r2", A_OFF, S_OFF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 16'h0, 4'h0); dig("r0", A_0, S_0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd1, 1'b0, 16'h0, 4'h0);
        step(1'b0, 2'd2, 1'b0, 16'h0, 4'h0);
        step(1'b0, 2'd3, 1'b0, 16'h0, 4'h0); dig("r3", A_3, S_OFF, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 16'h0, 4'h0); dig("r0b", A_0, S_0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 2'd1, 1'b0, 16'h0, 4'h0); dig("r1b", A_1, S_OFF, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 The block SHALL have parameter BLANK_LZ, default 1, meaning leading-zero blanking is enabled when 1.
REQ-002 The block SHALL have parameter ACTIVE_LOW, default 1, meaning the seg, an and dp outputs are inverted (low = lit/selected) when 1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port phase, input, 2 bits: the digit-scan phase from the upstream 2-bit modulo-4 counter (0,1,2,3,0,...).
REQ-006 The block SHALL have port data, input, 16 bits: four hex nibbles, where digit k is data[4k+3:4k].
REQ-007 The block SHALL have port load, input, 1 bit: request to capture data for display.
REQ-008 The block SHALL have port dp_in, input, 4 bits: decimal point per digit, where bit k belongs to digit k.
REQ-009 The block SHALL have port seg, output, 7 bits: segments {g,f,e,d,c,b,a}.
REQ-010 The block SHALL have port dp, output, 1 bit: decimal point of the selected digit.
REQ-011 The block SHALL have port an, output, 4 bits: digit enables, one-hot when selected, where bit k is digit k.
REQ-012 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse per completed scan frame.
REQ-013 The block SHALL have port seq_err, output, 1 bit: sticky flag for an illegal phase step.

Function
REQ-014 The block SHALL hold a pending register (16-bit data, 4-bit dp), a shadow register (same widths) and a 2-bit prev_phase register.
REQ-015 On a clock edge with load=1, the block SHALL write data/dp_in into pending; a later load before the commit SHALL overwrite it (last wins).
REQ-016 A boundary SHALL be defined as phase==0 with prev_phase==3; at a boundary edge the block SHALL copy pending to shadow.
REQ-017 If load and a boundary occur in the same cycle, the block SHALL commit the old pending to shadow and store the new data in pending for the next boundary.
REQ-018 prev_phase SHALL take the value of phase on every non-reset edge.
REQ-019 A legal step SHALL be phase==prev_phase (stall) or phase==prev_phase+1 mod 4; any other step SHALL set seq_err, which stays set until reset.
REQ-020 frame_done SHALL be registered and SHALL be 1 for exactly the cycle after a boundary edge, otherwise 0.
REQ-021 Outputs SHALL be registered with one-cycle latency: the value of phase p at edge n SHALL select digit p during cycle n+1.
REQ-022 The selected digit SHALL drive: an with only bit p active, seg with the hex decode of shadow nibble p, and dp with shadow dp bit p.
REQ-023 Hex decode (active-high, before polarity) SHALL be: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
REQ-024 With BLANK_LZ=1, digit k>0 SHALL be blanked (seg all off, an still selected) when shadow nibbles k..3 are all zero; digit 0 SHALL never be blanked, and dp SHALL not be blanked.
REQ-025 With ACTIVE_LOW=1, seg, dp and an SHALL be the bitwise inverse of the active-high values.
REQ-026 The block SHALL continue normal display operation while seq_err is set.

Reset
REQ-027 While reset=1 at an edge, the block SHALL clear pending and shadow to 0, set prev_phase=0, and clear frame_done and seq_err to 0.
REQ-028 In the cycle after a reset edge, an, seg and dp SHALL all be inactive (ACTIVE_LOW=1: an=1111, seg=1111111, dp=1).
REQ-029 Reset asserted mid-frame SHALL discard any pending load, and the phase 0 that follows SHALL raise no seq_err and no frame_done.

Verification
REQ-030 Reset, then phase 0,1,2,3,0 with no load (ACTIVE_LOW=1, BLANK_LZ=1) -> digit0 seg=1000000; digits1-3 seg=1111111; frame_done=1 once, the cycle after the second phase 0.
REQ-031 load with data=16'h12AF mid-frame -> display unchanged until the boundary; next frame shows digits F,A,2,1 on an=1110,1101,1011,0111.
REQ-032 data=16'h0070 loaded and committed -> digits 3 and 2 blanked, digit1 shows 7 (seg=1111000), digit0 shows 0; with BLANK_LZ=0 all four digits are lit.
REQ-033 load 16'h1111, then load 16'h2222 in the boundary cycle -> the next frame shows 1111, and 2222 appears only after the following boundary.
REQ-034 phase step 1->3 -> seq_err=1 on the next cycle and stays 1 through later legal frames; a stall of 2,2,2 leaves seq_err at 0.
REQ-035 Reset asserted at phase 2 with a load pending -> all outputs inactive, shadow=0, seq_err=0, and the pending value is never displayed.
